button_conditioner: RTL and testbench

- Multi-channel synchroniser, debouncer and edge detector for active-low push-button inputs such as Run, Continue and the board keys.
- Sits between the top-level pins and the CPU control logic.
- Per channel it produces:
  - a clean active-high level;
  - a single-cycle press pulse;
  - a single-cycle release pulse.
- Replaces per-button ad-hoc sync registers with one parametrised block.

---
 rtl/button_conditioner.sv | 118 +++++++++++
 tb/tb_button_conditioner.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchroniser, debouncer and press/release pulser for active-low buttons
// Optional macro AUTO_REPEAT_EN adds timed auto-repeat press pulses while a button stays held.
module button_conditioner #(
  parameter int N_CH            = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [N_CH-1:0] btn_n,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel    // release pulse; "release" is a reserved word
);

  if (N_CH < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("button_conditioner: all parameters must be >= 1");
  end

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;
  logic [N_CH-1:0] pressed;
  logic [N_CH-1:0] toggle;
  logic [N_CH-1:0] rpt_fire;
  logic [CW-1:0]   cnt     [N_CH];
  logic [CW-1:0]   cnt_nxt [N_CH];

  assign pressed = ~s2;

  // Any cycle where the synced value agrees with level restarts the stability count.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_nxt[i] = '0;
      if (pressed[i] != level[i]) begin
        if (cnt[i] == CNT_LAST) begin
          toggle[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      s1    <= '1;
      s2    <= '1;
      level <= '0;
      press <= '0;
      rel   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1    <= btn_n;
      s2    <= s1;
      level <= level ^ toggle;
      press <= (toggle & ~level) | rpt_fire;
      rel   <= toggle & level;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0]   rcnt     [N_CH];
  logic [RW-1:0]   rcnt_nxt [N_CH];
  logic [N_CH-1:0] rpt_seen;
  logic [N_CH-1:0] rpt_seen_nxt;

  // rpt_seen selects the initial delay versus the steady repeat period.
  always_comb begin
    rpt_fire     = '0;
    rpt_seen_nxt = rpt_seen;
    for (int i = 0; i < N_CH; i++) begin
      rcnt_nxt[i] = '0;
      if (level[i] && !toggle[i]) begin
        if (rcnt[i] == (rpt_seen[i] ? PERIOD_LAST : DELAY_LAST)) begin
          rpt_fire[i]     = 1'b1;
          rpt_seen_nxt[i] = 1'b1;
        end else begin
          rcnt_nxt[i] = rcnt[i] + 1'b1;
        end
      end else begin
        rpt_seen_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      rpt_seen <= '0;
      for (int i = 0; i < N_CH; i++) begin
        rcnt[i] <= '0;
      end
    end else begin
      rpt_seen <= rpt_seen_nxt;
      for (int i = 0; i < N_CH; i++) begin
        rcnt[i] <= rcnt_nxt[i];
      end
    end
  end
`else
  assign rpt_fire = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner against a window-based reference model
// Honours AUTO_REPEAT_EN in the model the same way the design does.
module tb_button_conditioner;
  localparam int N  = 3;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic [N-1:0] btn_n = '0;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] rel;

  button_conditioner #(
    .N_CH(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clk(Clk), .Reset(Reset), .btn_n(btn_n),
    .level(level), .press(press), .rel(rel)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference: two-edge input delay, then a level flips once the last D synced samples all disagree with it.
  logic [N-1:0] dly[$];
  logic [N-1:0] win[$];
  logic [N-1:0] m_level;
  int           edge_no = 0;
  int           press_edge[N];

  always @(posedge Clk) begin : model
    exp_t         e;
    logic [N-1:0] pr;
    bit           all_diff;
    int           k;
    e = '0;
    if (!Reset) begin
      dly.delete();
      dly.push_back('1);
      dly.push_back('1);
      win.delete();
      m_level = '0;
    end else begin
      pr = ~dly.pop_front();
      dly.push_back(btn_n);
      win.push_back(pr);
      if (win.size() > D) void'(win.pop_front());
      edge_no++;
      for (int ch = 0; ch < N; ch++) begin
        all_diff = (win.size() == D);
        foreach (win[w]) if (win[w][ch] == m_level[ch]) all_diff = 1'b0;
        if (all_diff) begin
          if (!m_level[ch]) begin
            e.press[ch] = 1'b1;
            press_edge[ch] = edge_no;
          end else begin
            e.rel[ch] = 1'b1;
          end
          m_level[ch] = ~m_level[ch];
        end
`ifdef AUTO_REPEAT_EN
        else if (m_level[ch]) begin
          k = edge_no - press_edge[ch];
          if (k == RD || (k > RD && (k - RD) % RP == 0)) e.press[ch] = 1'b1;
        end
`endif
      end
      e.level = m_level;
    end
    sb.push_back(e);
  end

  always @(posedge Clk) begin : monitor
    exp_t e;
    #1;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty t=%0t got level=%b press=%b release=%b", $time, level, press, rel);
    end else begin
      e = sb.pop_front();
      if ({level, press, rel} !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t got level=%b press=%b release=%b want level=%b press=%b release=%b",
                 $time, level, press, rel, e.level, e.press, e.rel);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  int hold[N];

  initial begin
    // reset with buttons held, then release reset while still held
    btn_n = '0;
    Reset = 1'b0;
    cyc(2);
    Reset = 1'b1;
    cyc(10);
    btn_n = '1;
    cyc(10);
    // single channel press and release
    btn_n = 3'b110;
    cyc(10);
    btn_n = '1;
    cyc(10);
    // bounce on channel 1 shorter than the debounce window
    btn_n = 3'b101; cyc(3);
    btn_n = '1;     cyc(1);
    btn_n = 3'b101; cyc(3);
    btn_n = '1;     cyc(10);
    // channels 0 and 2 together
    btn_n = 3'b010;
    cyc(10);
    btn_n = '1;
    cyc(10);
    // reset while held
    btn_n = 3'b110;
    cyc(8);
    Reset = 1'b0;
    cyc(1);
    Reset = 1'b1;
    cyc(10);
    btn_n = '1;
    cyc(10);
    // long hold for auto-repeat
    btn_n = 3'b110;
    cyc(30);
    btn_n = '1;
    cyc(15);
    // randomized mix of bounces, long holds and occasional resets
    for (int c = 0; c < N; c++) hold[c] = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          btn_n[c] = ~btn_n[c];
          hold[c] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, D)
                                                : $urandom_range(D, 4 * D + RD + 3 * RP);
        end
      end
      Reset = ($urandom_range(0, 499) != 0);
      cyc(1);
    end
    Reset = 1'b1;
    btn_n = '1;
    cyc(12);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
